// File: rtl/can_frame_fifo.sv
// Show-ahead frame FIFO between the host push/pull port and the CAN bit engine.
// Holds whole frames, reports occupancy and keeps sticky overflow/underflow flags.
module can_frame_fifo #(
   parameter int DATA_W      = 108,
   parameter int DEPTH_LOG2  = 4,
   parameter int AF_THRESH   = (2 ** DEPTH_LOG2) - 2,
   parameter int OVWR_OLDEST = 0
) (
   input  logic                  GCLK,
   input  logic                  RES,
   input  logic [DATA_W-1:0]     din,
   input  logic                  push,
   input  logic                  pop,
   output logic [DATA_W-1:0]     dout,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf,
   output logic                  udf,
   input  logic                  clr_flags
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

   if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
      $error("can_frame_fifo: DEPTH_LOG2 must be 1..8");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("can_frame_fifo: AF_THRESH must be 1..DEPTH");
   end
   if (OVWR_OLDEST != 0 && OVWR_OLDEST != 1) begin : g_bad_ovwr
      $error("can_frame_fifo: OVWR_OLDEST must be 0 or 1");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;

   logic do_wr;
   logic rd_adv;
   logic set_ovf;
   logic set_udf;

   // push/pop are single-cycle strobes with no back-pressure: a push is taken
   // unless full (drop-new policy), a pop is taken unless empty. Rejected
   // strobes are not retried; they only raise the matching sticky flag.
   always_comb begin
      do_wr   = 1'b0;
      rd_adv  = 1'b0;
      set_ovf = 1'b0;
      set_udf = 1'b0;
      if (pop && empty) begin
         set_udf = 1'b1;
      end
      if (pop && !empty) begin
         rd_adv = 1'b1;
      end
      if (push) begin
         if (!full || pop) begin
            do_wr = 1'b1;
         end else begin
            set_ovf = 1'b1;
            // Overwrite-oldest: the write displaces the head, so rd_ptr follows.
            if (OVWR_OLDEST != 0) begin
               do_wr  = 1'b1;
               rd_adv = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge GCLK) begin
      if (RES) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_adv) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (do_wr && !rd_adv) begin
            cnt <= cnt + CW'(1);
         end else if (rd_adv && !do_wr) begin
            cnt <= cnt - CW'(1);
         end
         ovf <= set_ovf | (ovf & ~clr_flags);
         udf <= set_udf | (udf & ~clr_flags);
      end
   end

   // Storage is deliberately left uncleared by reset.
   always_ff @(posedge GCLK) begin
      if (!RES && do_wr) begin
         mem[wr_ptr] <= din;
      end
   end

   assign empty       = (cnt == '0);
   assign full        = (cnt == DEPTH_C);
   assign almost_full = (cnt >= AF_C);
   assign count       = cnt;
   assign dout        = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_can_frame_fifo.sv
// Bench for can_frame_fifo: drop-new and overwrite-oldest instances share one
// stimulus stream and are checked against a queue-based frame model.
module tb_can_frame_fifo;

   localparam int DW  = 108;
   localparam int DL  = 2;
   localparam int DEP = 4;
   localparam int AF  = 3;
   localparam int OW  = DW + 8;

   logic          GCLK;
   logic          RES;
   logic [DW-1:0] din;
   logic          push;
   logic          pop;
   logic          clr_flags;

   logic [DW-1:0] dout0, dout1;
   logic          empty0, empty1, full0, full1, af0, af1, ovf0, ovf1, udf0, udf1;
   logic [DL:0]   count0, count1;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mq [2][$];
   bit            m_ovf [2];
   bit            m_udf [2];

   can_frame_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL), .AF_THRESH(AF), .OVWR_OLDEST(0)) dut_drop (
      .GCLK(GCLK), .RES(RES), .din(din), .push(push), .pop(pop),
      .dout(dout0), .empty(empty0), .full(full0), .almost_full(af0),
      .count(count0), .ovf(ovf0), .udf(udf0), .clr_flags(clr_flags)
   );

   can_frame_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL), .AF_THRESH(AF), .OVWR_OLDEST(1)) dut_ovwr (
      .GCLK(GCLK), .RES(RES), .din(din), .push(push), .pop(pop),
      .dout(dout1), .empty(empty1), .full(full1), .almost_full(af1),
      .count(count1), .ovf(ovf1), .udf(udf1), .clr_flags(clr_flags)
   );

   // clock / reset
   initial GCLK = 1'b0;
   always #5 GCLK = ~GCLK;

   function automatic logic [OW-1:0] obs(int m);
      if (m == 0) return {dout0, empty0, full0, af0, count0, ovf0, udf0};
      return {dout1, empty1, full1, af1, count1, ovf1, udf1};
   endfunction

   function automatic logic [OW-1:0] exp_vec(int m);
      int            sz;
      logic [DW-1:0] d;
      sz = mq[m].size();
      d  = (sz > 0) ? mq[m][0] : '0;
      return {d, sz == 0, sz == DEP, sz >= AF, 3'(sz), m_ovf[m], m_udf[m]};
   endfunction

   // Reference: a frame queue per policy, updated from the cycle's strobes.
   task automatic model_step(input bit p, input bit q, input bit c, input bit r,
                             input logic [DW-1:0] d);
      for (int m = 0; m < 2; m++) begin
         int sz;
         bit so, su;
         if (r) begin
            mq[m].delete();
            m_ovf[m] = 0;
            m_udf[m] = 0;
         end else begin
            sz = mq[m].size();
            so = 0;
            su = 0;
            if (q && sz == 0) su = 1;
            if (p && q && sz > 0) begin
               void'(mq[m].pop_front());
               mq[m].push_back(d);
            end else if (p) begin
               if (sz < DEP) begin
                  mq[m].push_back(d);
               end else begin
                  so = 1;
                  if (m == 1) begin
                     void'(mq[m].pop_front());
                     mq[m].push_back(d);
                  end
               end
            end else if (q && sz > 0) begin
               void'(mq[m].pop_front());
            end
            m_ovf[m] = c ? so : (m_ovf[m] | so);
            m_udf[m] = c ? su : (m_udf[m] | su);
         end
      end
   endtask

   // driver: called at a negedge, returns at the following negedge
   task automatic drive(input bit p, input bit q, input bit c, input bit r,
                        input logic [DW-1:0] d);
      push = p; pop = q; clr_flags = c; RES = r; din = d;
      @(posedge GCLK);
      model_step(p, q, c, r, d);
      @(negedge GCLK);
      push = 0; pop = 0; clr_flags = 0; RES = 0;
   endtask

   function automatic logic [DW-1:0] rand_frame();
      logic [127:0] w;
      w = {$urandom, $urandom, $urandom, $urandom};
      return w[DW-1:0];
   endfunction

   task automatic test_reset();
      drive(0, 0, 0, 1, '0);
      drive(0, 0, 0, 1, '0);
      for (int m = 0; m < 2; m++) begin
         n_cmp++;
         if (obs(m) !== exp_vec(m)) begin
            n_err++;
            $display("FAIL reset dut%0d: got %h want %h", m, obs(m), exp_vec(m));
         end
      end
      n_cmp++;
      if ({empty0, full0, af0, ovf0, udf0, dout0} !== {1'b1, 4'b0, {DW{1'b0}}}) begin
         n_err++;
         $display("FAIL reset_const: got %b want 10000 dout=0", {empty0, full0, af0, ovf0, udf0});
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, DW'(8'hA1 + i));
         for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== exp_vec(m)) begin
               n_err++;
               $display("FAIL fill[%0d] dut%0d: got %h want %h", i, m, obs(m), exp_vec(m));
            end
         end
         n_cmp++;
         if ({count0, af0, full0, dout0} !== {3'(i + 1), i >= 2, i == 3, DW'(8'hA1)}) begin
            n_err++;
            $display("FAIL fill_const[%0d]: got count=%0d af=%b full=%b dout=%h", i, count0,
                     af0, full0, dout0);
         end
      end
   endtask

   task automatic test_overflow();
      drive(1, 0, 0, 0, DW'(8'hA5));
      for (int m = 0; m < 2; m++) begin
         n_cmp++;
         if (obs(m) !== exp_vec(m)) begin
            n_err++;
            $display("FAIL ovf_push dut%0d: got %h want %h", m, obs(m), exp_vec(m));
         end
      end
      n_cmp++;
      if ({ovf0, ovf1, count0, count1, dout0, dout1} !==
          {2'b11, 3'd4, 3'd4, DW'(8'hA1), DW'(8'hA2)}) begin
         n_err++;
         $display("FAIL ovf_const: got ovf=%b%b cnt=%0d/%0d dout=%h/%h want 11 4/4 a1/a2",
                  ovf0, ovf1, count0, count1, dout0, dout1);
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 0, '0);
         for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== exp_vec(m)) begin
               n_err++;
               $display("FAIL ovf_drain[%0d] dut%0d: got %h want %h", i, m, obs(m), exp_vec(m));
            end
         end
      end
      drive(0, 0, 1, 0, '0);
   endtask

   task automatic test_empty_push_pop();
      drive(1, 1, 0, 0, DW'(8'hB0));
      for (int m = 0; m < 2; m++) begin
         n_cmp++;
         if (obs(m) !== exp_vec(m)) begin
            n_err++;
            $display("FAIL pp_empty dut%0d: got %h want %h", m, obs(m), exp_vec(m));
         end
      end
      n_cmp++;
      if ({udf0, count0, dout0} !== {1'b1, 3'd1, DW'(8'hB0)}) begin
         n_err++;
         $display("FAIL pp_empty_const: got udf=%b count=%0d dout=%h", udf0, count0, dout0);
      end
      drive(0, 1, 0, 0, '0);
      drive(0, 1, 1, 0, '0);
      n_cmp++;
      if ({udf0, udf1, empty0} !== 3'b111) begin
         n_err++;
         $display("FAIL clr_vs_set: got udf=%b%b empty=%b want 111", udf0, udf1, empty0);
      end
      drive(0, 0, 1, 0, '0);
      for (int m = 0; m < 2; m++) begin
         n_cmp++;
         if (obs(m) !== exp_vec(m)) begin
            n_err++;
            $display("FAIL clr dut%0d: got %h want %h", m, obs(m), exp_vec(m));
         end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, rand_frame());
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 0, 0, DW'(8'hC0 + i));
         for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== exp_vec(m)) begin
               n_err++;
               $display("FAIL wrap[%0d] dut%0d: got %h want %h", i, m, obs(m), exp_vec(m));
            end
         end
      end
      n_cmp++;
      if ({count0, ovf0, dout0} !== {3'd4, 1'b0, DW'(8'hC2)}) begin
         n_err++;
         $display("FAIL wrap_const: got count=%0d ovf=%b dout=%h want 4 0 c2", count0, ovf0, dout0);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0, '0);
         for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== exp_vec(m)) begin
               n_err++;
               $display("FAIL wrap_drain[%0d] dut%0d: got %h want %h", i, m, obs(m), exp_vec(m));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, rand_frame());
      drive(0, 1, 0, 0, '0);
      drive(0, 1, 0, 0, '0);
      drive(0, 1, 0, 0, '0);
      drive(0, 1, 0, 0, '0);
      drive(1, 0, 0, 0, rand_frame());
      drive(1, 0, 0, 0, rand_frame());
      drive(1, 0, 0, 0, rand_frame());
      drive(1, 0, 0, 1, rand_frame());
      for (int m = 0; m < 2; m++) begin
         n_cmp++;
         if (obs(m) !== exp_vec(m)) begin
            n_err++;
            $display("FAIL res_mid dut%0d: got %h want %h", m, obs(m), exp_vec(m));
         end
      end
      n_cmp++;
      if ({count0, empty0, ovf0, udf0} !== {3'd0, 1'b1, 2'b00}) begin
         n_err++;
         $display("FAIL res_mid_const: got count=%0d empty=%b ovf=%b udf=%b", count0, empty0,
                  ovf0, udf0);
      end
      drive(1, 0, 0, 0, DW'(8'hD0));
      n_cmp++;
      if ({dout0, dout1} !== {DW'(8'hD0), DW'(8'hD0)}) begin
         n_err++;
         $display("FAIL res_mid_push: got %h / %h want d0", dout0, dout1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
               $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, rand_frame());
         for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== exp_vec(m)) begin
               n_err++;
               $display("FAIL random[%0d] dut%0d: got %h want %h", i, m, obs(m), exp_vec(m));
            end
         end
      end
   endtask

   initial begin
      RES = 1; push = 0; pop = 0; clr_flags = 0; din = '0;
      @(negedge GCLK);
      test_reset();
      test_fill();
      test_overflow();
      test_empty_push_pop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
